// File: rtl/ddr_a2m_rd_err_resp.sv
// Read error responder: absorbs AR requests flagged as unsupported and returns
// ARLEN+1 SLVERR beats locally. Optional accept counter: DDR_A2M_RERR_CNT_EN.
//
// state  | meaning
// S_IDLE | ready for a flagged request, no R beat presented
// S_RESP | presenting SLVERR beats until the RLAST handshake
module ddr_a2m_rd_err_resp #(
    parameter int P_ID_W   = 8,
    parameter int P_DATA_W = 128
) (
    input  logic                aclk_i,
    input  logic                aresetn_i,
    input  logic                err_valid_i,
    output logic                err_ready_o,
    input  logic [P_ID_W-1:0]   err_id_i,
    input  logic [7:0]          err_len_i,
    output logic                rvalid_o,
    input  logic                rready_i,
    output logic [P_ID_W-1:0]   rid_o,
    output logic [P_DATA_W-1:0] rdata_o,
    output logic [1:0]          rresp_o,
    output logic                rlast_o,
    output logic                err_busy_o
`ifdef DDR_A2M_RERR_CNT_EN
    ,
    output logic [15:0]         err_cnt_o
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t              state_q;
    logic [7:0]          rem_q;
    logic [P_ID_W-1:0]   id_q;
    logic                rlast_q;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            id_q    <= '0;
            rlast_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (err_valid_i) begin
                        state_q <= S_RESP;
                        rem_q   <= err_len_i;
                        id_q    <= err_id_i;
                        rlast_q <= (err_len_i == 8'd0);
                    end
                end
                S_RESP: begin
                    if (rready_i) begin
                        if (rem_q == 8'd0) begin
                            state_q <= S_IDLE;
                            rlast_q <= 1'b0;
                        end else begin
                            rem_q   <= rem_q - 8'd1;
                            // RLAST is pre-computed so it is a flop output
                            rlast_q <= (rem_q == 8'd1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign err_ready_o = (state_q == S_IDLE);
    assign rvalid_o    = (state_q == S_RESP);
    assign err_busy_o  = (state_q == S_RESP);
    assign rid_o       = id_q;
    assign rdata_o     = '0;
    assign rresp_o     = (state_q == S_RESP) ? 2'b10 : 2'b00;
    assign rlast_o     = rlast_q;

`ifdef DDR_A2M_RERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            err_cnt_q <= '0;
        end else if (err_valid_i && (state_q == S_IDLE) && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_a2m_rd_err_resp.sv
// Scoreboard bench for ddr_a2m_rd_err_resp: requests push expected beats,
// a negedge monitor pops and compares each R handshake.
module tb_ddr_a2m_rd_err_resp;

    localparam int ID_W = 8;
    localparam int DW   = 128;

    logic            clk = 1'b0;
    logic            aresetn = 1'b0;
    logic            err_valid = 1'b0;
    logic            err_ready_o;
    logic [ID_W-1:0] err_id = '0;
    logic [7:0]      err_len = '0;
    logic            rvalid_o;
    logic            rready = 1'b0;
    logic [ID_W-1:0] rid_o;
    logic [DW-1:0]   rdata_o;
    logic [1:0]      rresp_o;
    logic            rlast_o;
    logic            err_busy_o;
`ifdef DDR_A2M_RERR_CNT_EN
    logic [15:0]     err_cnt_o;
`endif

    always #5 clk = ~clk;

    ddr_a2m_rd_err_resp #(.P_ID_W(ID_W), .P_DATA_W(DW)) dut (
        .aclk_i      (clk),
        .aresetn_i   (aresetn),
        .err_valid_i (err_valid),
        .err_ready_o (err_ready_o),
        .err_id_i    (err_id),
        .err_len_i   (err_len),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready),
        .rid_o       (rid_o),
        .rdata_o     (rdata_o),
        .rresp_o     (rresp_o),
        .rlast_o     (rlast_o),
        .err_busy_o  (err_busy_o)
`ifdef DDR_A2M_RERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    typedef struct {
        logic [7:0] id;
        logic       last;
    } beat_t;

    beat_t exp_q[$];
    bit    rdy_pat[$];
    bit    rdy_rand = 1'b0;
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    hs_cnt = 0;
    int    last_hs_edge = -10;
    int    exp_cnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(string nm, longint act, longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Ready driver: directed pattern while a beat is up, otherwise random or all-ones.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rvalid_o && rdy_pat.size() > 0) rready = rdy_pat.pop_front();
            else if (rdy_rand)                  rready = 1'($urandom_range(0, 1));
            else                                rready = 1'b1;
        end
    end

    // Monitor: everything is sampled at negedge, handshake completes at the next posedge.
    initial begin
        bit         stall = 1'b0;
        bit         post_last = 1'b0;
        logic [7:0] s_id = '0;
        logic       s_last = 1'b0;
        beat_t      e;
        forever begin
            @(negedge clk);
            if (!aresetn) begin
                stall = 1'b0;
                post_last = 1'b0;
                continue;
            end
            chk("busy_vs_valid", err_busy_o, rvalid_o);
            chk("ready_vs_valid", err_ready_o, !rvalid_o);
            if (!rvalid_o) begin
                chk("rlast_idle", rlast_o, 0);
                chk("rresp_idle", rresp_o, 0);
            end else begin
                chk("rresp_slverr", rresp_o, 2);
                chk("rdata_zero", (rdata_o == '0), 1);
            end
            if (stall) begin
                chk("stall_valid", rvalid_o, 1);
                chk("stall_rid", rid_o, s_id);
                chk("stall_rlast", rlast_o, s_last);
            end
            if (post_last) chk("gap_after_last", rvalid_o, 0);
            post_last = 1'b0;
            if (rvalid_o && rready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat rid=%0h rlast=%0b expected no beat", rid_o, rlast_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("rid", rid_o, e.id);
                    chk("rlast", rlast_o, e.last);
                end
                hs_cnt++;
                if (rlast_o) begin
                    post_last = 1'b1;
                    last_hs_edge = cyc + 1;
                end
                stall = 1'b0;
            end else if (rvalid_o) begin
                stall = 1'b1;
                s_id = rid_o;
                s_last = rlast_o;
            end else begin
                stall = 1'b0;
            end
        end
    end

    task automatic send(input logic [7:0] id, input logic [7:0] len, output int acc_edge);
        int t;
        acc_edge = -1;
        @(negedge clk);
        err_valid = 1'b1;
        err_id = id;
        err_len = len;
        t = 0;
        while (!err_ready_o) begin
            @(negedge clk);
            t++;
            if (t > 2000) begin
                checks++;
                failures++;
                $display("FAIL accept_timeout id=%0h waited=%0d cycles", id, t);
                err_valid = 1'b0;
                return;
            end
        end
        acc_edge = cyc + 1;
        for (int b = 0; b <= int'(len); b++) exp_q.push_back('{id, (b == int'(len))});
        if (exp_cnt < 65535) exp_cnt++;
        @(posedge clk);
        #1;
        err_valid = 1'b0;
        err_id = 8'($urandom);
        err_len = 8'($urandom);
        @(negedge clk);
        chk("first_beat_latency", rvalid_o, 1);
    endtask

    task automatic wait_drain();
        int t = 0;
        while (exp_q.size() != 0 || rvalid_o) begin
            @(negedge clk);
            t++;
            if (t > 3000) begin
                checks++;
                failures++;
                $display("FAIL drain_timeout pending=%0d expected 0", exp_q.size());
                exp_q.delete();
                return;
            end
        end
    endtask

    initial begin
        int acc;
        int acc2;
        int base;
        int t;

        repeat (3) @(posedge clk);
        #2;
        chk("rst_rvalid", rvalid_o, 0);
        chk("rst_rlast", rlast_o, 0);
        chk("rst_rresp", rresp_o, 0);
        chk("rst_rid", rid_o, 0);
        chk("rst_busy", err_busy_o, 0);
        @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_rst", err_ready_o, 1);

        // single beat
        send(8'h3C, 8'd0, acc);
        @(negedge clk);
        chk("ready_after_single", err_ready_o, 1);

        // four back-to-back beats
        base = hs_cnt;
        send(8'h05, 8'd3, acc);
        wait_drain();
        chk("len3_beats", hs_cnt - base, 4);

        // stalled burst
        rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        base = hs_cnt;
        send(8'h6B, 8'd2, acc);
        wait_drain();
        chk("stall_handshakes", hs_cnt - base, 3);
        rdy_pat.delete();

        // max length, then next request immediately behind it
        base = hs_cnt;
        send(8'h9E, 8'd255, acc);
        send(8'h42, 8'd2, acc2);
        chk("b2b_accept_edge", acc2, last_hs_edge + 1);
        wait_drain();
        chk("len255_plus3_beats", hs_cnt - base, 259);

        // reset in the middle of an 8-beat burst
        base = hs_cnt;
        send(8'hA7, 8'd7, acc);
        t = 0;
        while (hs_cnt < base + 2 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        @(posedge clk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_rvalid", rvalid_o, 0);
        chk("midrst_rlast", rlast_o, 0);
        chk("midrst_rresp", rresp_o, 0);
        chk("midrst_rid", rid_o, 0);
        chk("midrst_busy", err_busy_o, 0);
        exp_q.delete();
        exp_cnt = 0;
        repeat (3) @(negedge clk);
        aresetn = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", err_ready_o, 1);
        base = hs_cnt;
        send(8'h11, 8'd1, acc);
        wait_drain();
        chk("post_rst_beats", hs_cnt - base, 2);

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            rdy_rand = 1'($urandom_range(0, 1));
            send(8'($urandom), ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5)), acc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rdy_rand = 1'b0;
        wait_drain();

`ifdef DDR_A2M_RERR_CNT_EN
        @(negedge clk);
        chk("err_cnt", err_cnt_o, exp_cnt);
        force dut.err_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.err_cnt_q;
        exp_cnt = 65535;
        send(8'h77, 8'd0, acc);
        wait_drain();
        @(negedge clk);
        chk("err_cnt_sat", err_cnt_o, exp_cnt);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
